// File: rtl/dna_edit_pkg.sv
// Shared constants, types and helpers for the DNA word editor.
// The optional out_err port is enabled by defining DNA_EDIT_ERR_EN.
package dna_edit_pkg;

    localparam int N      = 6;
    localparam int MAX_ED = 4;
    localparam int IDX_W  = 7;
    localparam int D      = N + MAX_ED;
    localparam int NE_W   = $clog2(MAX_ED + 1);
    localparam int LEN_W  = $clog2(D + 1);
    localparam int W_IN   = 2 * N;
    localparam int W_OUT  = 2 * D;

    localparam logic [1:0] DIG_A = 2'd0;
    localparam logic [1:0] DIG_C = 2'd1;
    localparam logic [1:0] DIG_G = 2'd2;
    localparam logic [1:0] DIG_T = 2'd3;

    typedef enum logic [1:0] {OP_NOP, OP_SUB, OP_INS, OP_DEL} ed_op_t;
    typedef enum logic [1:0] {IDLE, EDIT, OUT} state_t;

    // The working buffer keeps digit 0 in the MSBs; the output is right-aligned.
    function automatic logic [W_OUT-1:0] right_align(input logic [W_OUT-1:0] word,
                                                     input logic [LEN_W-1:0] len);
        return word >> (2 * (D - int'(len)));
    endfunction

endpackage

// File: rtl/dna_edit_apply.sv
// Combinational single-edit shift network over a left-aligned digit buffer.
// Digits at positions >= len are kept at zero so shifts never drag in garbage.
module dna_edit_apply
    import dna_edit_pkg::*;
(
    input  logic [W_OUT-1:0] word,
    input  logic [LEN_W-1:0] len,
    input  ed_op_t           op,
    input  logic [IDX_W-1:0] index,
    input  logic [1:0]       digit,
    output logic [W_OUT-1:0] next_word,
    output logic [LEN_W-1:0] next_len,
    output logic             range_err
);

    logic [IDX_W-1:0] len_x;
    assign len_x = IDX_W'(len);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_word = word;
        next_len  = len;
        range_err = 1'b0;
        case (op)
            OP_SUB: begin
                if (index < len_x) begin
                    for (int j = 0; j < D; j++)
                        if (IDX_W'(j) == index) next_word[2*(D-1-j) +: 2] = digit;
                end else begin
                    range_err = 1'b1;
                end
            end
            OP_INS: begin
                if (index <= len_x && len_x < IDX_W'(D)) begin
                    for (int j = 1; j < D; j++)
                        if (IDX_W'(j) > index) next_word[2*(D-1-j) +: 2] = word[2*(D-j) +: 2];
                    for (int j = 0; j < D; j++)
                        if (IDX_W'(j) == index) next_word[2*(D-1-j) +: 2] = digit;
                    next_len = len + LEN_W'(1);
                end else begin
                    range_err = 1'b1;
                end
            end
            OP_DEL: begin
                if (index < len_x) begin
                    for (int j = 0; j < D - 1; j++)
                        if (IDX_W'(j) >= index) next_word[2*(D-1-j) +: 2] = word[2*(D-2-j) +: 2];
                    next_word[1:0] = 2'b00;
                    next_len = len - LEN_W'(1);
                end else begin
                    range_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dna_word_editor.sv
// Multi-edit DNA word corrector: load a base word, apply up to MAX_ED edits, emit it.
// Define DNA_EDIT_ERR_EN to expose the sticky out_err flag.
module dna_word_editor
    import dna_edit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_word,
    input  logic [NE_W-1:0]  in_nedits,
    input  logic             ed_valid,
    output logic             ed_ready,
    input  logic [1:0]       ed_op,
    input  logic [IDX_W-1:0] ed_index,
    input  logic [1:0]       ed_digit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_word,
    output logic [LEN_W-1:0] out_len
`ifdef DNA_EDIT_ERR_EN
    ,
    output logic             out_err
`endif
);

    state_t           state_q, state_d;
    logic [W_OUT-1:0] word_q, word_d, ap_word;
    logic [LEN_W-1:0] len_q, len_d, ap_len;
    logic [NE_W-1:0]  rem_q, rem_d, nedits_clamped;
    logic             err_q, err_d, ap_err, in_ready_q, out_err_q;

    dna_edit_apply u_apply (
        .word      (word_q),
        .len       (len_q),
        .op        (ed_op_t'(ed_op)),
        .index     (ed_index),
        .digit     (ed_digit),
        .next_word (ap_word),
        .next_len  (ap_len),
        .range_err (ap_err)
    );

    assign nedits_clamped = (in_nedits > NE_W'(MAX_ED)) ? NE_W'(MAX_ED) : in_nedits;
    assign in_ready       = in_ready_q;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        len_d     = len_q;
        rem_d     = rem_q;
        err_d     = err_q;
        ed_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    word_d  = {in_word, {(2*MAX_ED){1'b0}}};
                    len_d   = LEN_W'(N);
                    rem_d   = nedits_clamped;
                    err_d   = (in_nedits > NE_W'(MAX_ED));
                    state_d = (nedits_clamped == '0) ? OUT : EDIT;
                end
            end
            EDIT: begin
                ed_ready = 1'b1;
                if (ed_valid) begin
                    word_d = ap_word;
                    len_d  = ap_len;
                    err_d  = err_q | ap_err;
                    rem_d  = rem_q - NE_W'(1);
                    if (rem_q == NE_W'(1)) state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low throughout reset and rises on the first edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments; every register is reset
            // because an abort must leave no trace of the partial word.
            state_q    <= IDLE;
            word_q     <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            out_word   <= '0;
            out_len    <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            in_ready_q <= (state_d == IDLE);
            if (state_q != OUT && state_d == OUT) begin
                out_word  <= right_align(word_d, len_d);
                out_len   <= len_d;
                out_err_q <= err_d;
            end
        end
    end

`ifdef DNA_EDIT_ERR_EN
    assign out_err = out_err_q;
`else
    logic unused_err;
    assign unused_err = out_err_q;
`endif

endmodule

// File: tb/tb_dna_word_editor.sv
// Self-checking bench for dna_word_editor: directed scenarios plus random words checked
// against a queue-based model of the edit rules. Honours DNA_EDIT_ERR_EN when defined.
module tb_dna_word_editor;

    localparam int TN = 6;
    localparam int TMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_word = '0;
    logic [2:0]  in_nedits = '0;
    logic        ed_valid = 1'b0;
    logic        ed_ready;
    logic [1:0]  ed_op = '0;
    logic [6:0]  ed_index = '0;
    logic [1:0]  ed_digit = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_word;
    logic [3:0]  out_len;
    logic        err_obs;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    int  mq[$];
    bit  merr;

    dna_word_editor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_nedits (in_nedits),
        .ed_valid  (ed_valid),
        .ed_ready  (ed_ready),
        .ed_op     (ed_op),
        .ed_index  (ed_index),
        .ed_digit  (ed_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_len   (out_len)
`ifdef DNA_EDIT_ERR_EN
        ,
        .out_err   (err_obs)
`endif
    );

`ifndef DNA_EDIT_ERR_EN
    assign err_obs = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    task automatic model_load(input logic [11:0] w, input int n);
        mq.delete();
        for (int i = 0; i < TN; i++) mq.push_back(int'((w >> (2 * (TN - 1 - i))) & 12'h3));
        merr = (n > TMAX);
    endtask

    task automatic model_edit(input int op, input int idx, input int d);
        case (op)
            1: if (idx < mq.size()) mq[idx] = d; else merr = 1;
            2: if (idx <= mq.size()) mq.insert(idx, d); else merr = 1;
            3: if (idx < mq.size()) mq.delete(idx); else merr = 1;
            default: ;
        endcase
    endtask

    function automatic logic [19:0] model_word();
        logic [19:0] r = '0;
        foreach (mq[i]) r = (r << 2) | 20'(mq[i]);
        return r;
    endfunction

    function automatic bit model_err_visible();
`ifdef DNA_EDIT_ERR_EN
        return merr;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [11:0] w, input int n);
        int g = 0;
        in_word = w;
        in_nedits = 3'(n);
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL word_accept_timeout in_ready=%0b want 1", in_ready);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_edit(input int op, input int idx, input int d, input int gap);
        int g = 0;
        ed_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        ed_op = 2'(op);
        ed_index = 7'(idx);
        ed_digit = 2'(d);
        ed_valid = 1'b1;
        while (!ed_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (!ed_ready) begin
            total++; bad++;
            $display("FAIL edit_accept_timeout ed_ready=%0b want 1", ed_ready);
        end
        @(posedge clk); #1;
        ed_valid = 1'b0;
    endtask

    // Collects the output beat; comparisons are done by each caller.
    task automatic get_out(input int hold, output logic [19:0] w, output logic [3:0] l,
                           output logic e, output int lat);
        int g = 0;
        out_ready = 1'b0;
        while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL out_valid_timeout out_valid=%0b want 1", out_valid);
        end
        lat = cyc - acc_cyc;
        repeat (hold) begin @(posedge clk); #1; end
        w = out_word;
        l = out_len;
        e = err_obs;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        #12;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want 0", in_ready); end
        total++; if (ed_ready !== 1'b0) begin bad++; $display("FAIL reset_ed_ready got=%0b want 0", ed_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want 0", out_valid); end
        total++; if (out_word !== 20'h0 || out_len !== 4'd0 || err_obs !== 1'b0) begin
            bad++; $display("FAIL reset_out_regs word=%h len=%0d err=%0b want 0/0/0", out_word, out_len, err_obs);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%0b want 1", in_ready); end
    endtask

    task automatic test_ins();
        logic [19:0] w; logic [3:0] l; logic e; int lat;
        send_word(12'h1B1, 1);
        send_edit(2, 2, 2, 0);
        get_out(0, w, l, e, lat);
        total++; if (w !== 20'h006B1 || l !== 4'd7) begin
            bad++; $display("FAIL ins_g2 word=%h len=%0d want 006b1/7", w, l);
        end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ins_g2_err got=%0b want 0", e); end
        total++; if (lat !== 1) begin bad++; $display("FAIL ins_g2_latency got=%0d want 1", lat); end
    endtask

    task automatic test_del();
        logic [19:0] w; logic [3:0] l; logic e; int lat;
        send_word(12'h1B1, 1);
        send_edit(3, 0, 0, 0);
        get_out(0, w, l, e, lat);
        total++; if (w !== 20'h001B1 || l !== 4'd5) begin
            bad++; $display("FAIL del_0 word=%h len=%0d want 001b1/5", w, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] w; logic [3:0] l; logic e; int lat;
        send_word(12'h1B1, 4);
        send_edit(1, 5, 3, 0);
        send_edit(2, 0, 0, 0);
        send_edit(3, 6, 0, 0);
        send_edit(0, 0, 0, 0);
        get_out(0, w, l, e, lat);
        total++; if (w !== 20'h0006C || l !== 4'd6) begin
            bad++; $display("FAIL four_edits word=%h len=%0d want 0006c/6", w, l);
        end
        total++; if (lat !== 4) begin bad++; $display("FAIL four_edits_latency got=%0d want 4", lat); end
    endtask

    task automatic test_range();
        logic [19:0] w; logic [3:0] l; logic e; int lat;
        send_word(12'h1B1, 1);
        send_edit(2, 7, 1, 0);
        get_out(0, w, l, e, lat);
        total++; if (w !== 20'h001B1 || l !== 4'd6) begin
            bad++; $display("FAIL range_ins7 word=%h len=%0d want 001b1/6", w, l);
        end
`ifdef DNA_EDIT_ERR_EN
        total++; if (e !== 1'b1) begin bad++; $display("FAIL range_err_set got=%0b want 1", e); end
`endif
        send_word(12'h1B1, 0);
        get_out(0, w, l, e, lat);
        total++; if (e !== 1'b0 || w !== 20'h001B1) begin
            bad++; $display("FAIL range_err_clear err=%0b word=%h want 0/001b1", e, w);
        end
    endtask

    task automatic test_hold();
        logic [19:0] first;
        send_word(12'h2D8, 0);
        first = out_word;
        total++; if (out_valid !== 1'b1 || first !== 20'h002D8) begin
            bad++; $display("FAIL hold_first valid=%0b word=%h want 1/002d8", out_valid, first);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_word !== first || out_len !== 4'd6 || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d valid=%0b word=%h len=%0d in_ready=%0b want 1/%h/6/0",
                                i, out_valid, out_word, out_len, in_ready, first);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] w; logic [3:0] l; logic e; int lat;
        send_word(12'h1B1, 3);
        send_edit(2, 0, 3, 0);
        send_edit(1, 1, 2, 0);
        #2 rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0 || ed_ready !== 1'b0 || out_valid !== 1'b0 ||
                     out_word !== 20'h0 || out_len !== 4'd0 || err_obs !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs in_rdy=%0b ed_rdy=%0b ov=%0b word=%h len=%0d err=%0b want all 0",
                            in_ready, ed_ready, out_valid, out_word, out_len, err_obs);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || ed_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_idle in_ready=%0b ed_ready=%0b want 1/0", in_ready, ed_ready);
        end
        send_word(12'h1B1, 0);
        get_out(0, w, l, e, lat);
        total++; if (w !== 20'h001B1 || l !== 4'd6) begin
            bad++; $display("FAIL midreset_fresh word=%h len=%0d want 001b1/6", w, l);
        end
        total++; if (lat !== 0) begin bad++; $display("FAIL midreset_latency got=%0d want 0", lat); end
    endtask

    task automatic test_random();
        logic [19:0] w; logic [3:0] l; logic e; int lat;
        logic [11:0] base;
        int n, k, op, idx, d, gap, gaps;
        for (int t = 0; t < 60; t++) begin
            base = 12'($urandom);
            n = $urandom_range(0, 7);
            k = (n > TMAX) ? TMAX : n;
            model_load(base, n);
            send_word(base, n);
            gaps = 0;
            for (int j = 0; j < k; j++) begin
                op = $urandom_range(0, 3);
                idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127)
                                                  : $urandom_range(0, mq.size() + 1);
                d = $urandom_range(0, 3);
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                gaps += gap;
                model_edit(op, idx, d);
                send_edit(op, idx, d, gap);
            end
            get_out($urandom_range(0, 2), w, l, e, lat);
            total++; if (w !== model_word() || l !== 4'(mq.size())) begin
                bad++; $display("FAIL rand%0d_word word=%h len=%0d want %h/%0d", t, w, l, model_word(), mq.size());
            end
            total++; if (e !== model_err_visible()) begin
                bad++; $display("FAIL rand%0d_err got=%0b want %0b", t, e, model_err_visible());
            end
            total++; if (lat !== k + gaps) begin
                bad++; $display("FAIL rand%0d_latency got=%0d want %0d", t, lat, k + gaps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ins();
        test_del();
        test_back_to_back();
        test_range();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dna_word_editor.md
# dna_word_editor

Sequential multi-edit corrector for DNA words of 2-bit digits. It accepts one base word of N digits and then up to MAX_ED edit commands, one per cycle. Each command is a substitute, insert or delete at a digit index. It emits the corrected, variable-length word through a valid/ready handshake. It sits downstream of the decoder's error locator, alongside the single-insertion path, and handles mixed insertion/deletion/substitution error patterns.

## Interface
- N, 6, base word length in digits
- MAX_ED, 4, maximum edits per word; output capacity is N+MAX_ED digits
- IDX_W, 7, index width
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- in_valid  in  1  base word offered
- in_ready  out  1  block can take a base word
- in_word  in  2*N  base word; digit 0 in the MSBs
- in_nedits  in  $clog2(MAX_ED+1)  number of edit beats that follow
- ed_valid  in  1  edit offered
- ed_ready  out  1  block can take an edit
- ed_op  in  2  0 NOP, 1 SUB, 2 INS, 3 DEL
- ed_index  in  IDX_W  target digit index, counted from the MSB (0 = first digit)
- ed_digit  in  2  digit for SUB/INS; encoding A=0, C=1, G=2, T=3
- out_valid  out  1  corrected word available
- out_ready  in  1  consumer accepts
- out_word  out  2*(N+MAX_ED)  right-aligned; digit 0 at bits [2*out_len-1 -: 2]; unused MSBs are 0
- out_len  out  $clog2(N+MAX_ED+1)  valid digit count
- out_err  out  1  only present under DNA_EDIT_ERR_EN

## Operation
- FSM states: IDLE, EDIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load in_word, set len=N and rem=min(in_nedits,MAX_ED).
  - Go to OUT if rem==0, otherwise to EDIT.
- EDIT:
  - ed_ready=1.
  - Each accepted edit is applied to the buffer in its acceptance cycle and decrements rem.
  - The beat that brings rem to 0 moves the FSM to OUT.
- OUT:
  - out_valid=1.
  - On out_ready, go to IDLE.
- Edit semantics, with len taken before the edit:
  - SUB: valid for i<len; digit i is replaced.
  - INS: valid for i<=len; the new digit becomes digit i, old digits i..len-1 shift one position later, len+1.
  - DEL: valid for i<len; digit i is removed, later digits shift one position earlier, len-1, and vacated bits go to 0.
  - NOP: consumes a beat, no change.
- Edits apply in arrival order. Each index refers to the word as it stands after all prior edits.
- An out-of-range edit is ignored but still consumes its beat.
- Length never exceeds N+MAX_ED, because the number of edits is clamped.
- An in_nedits value above MAX_ED is clamped to MAX_ED and flagged as an error.

## Timing
- Reset values:
  - Outputs: in_ready=0 while reset is asserted, then 1 in the first cycle after release. ed_ready=0, out_valid=0, out_word=0, out_len=0, out_err=0.
  - Internal: state is IDLE.
- Reset asserted in any state aborts the word. Partial edits are discarded.
- Latency:
  - Word accepted in cycle t with 0 edits: out_valid in t+1.
  - With k edits accepted back-to-back from t+1: out_valid in t+k+1.
- Gaps in ed_valid stall EDIT with no timeout.
- No overlap between words: in_ready=0 in EDIT and OUT.
- out_word, out_len and out_err are registered. They are held stable while out_valid&&!out_ready.
- ed_valid in IDLE or OUT is ignored (ed_ready=0).

## Configuration
- DNA_EDIT_ERR_EN defined:
  - out_err port exists.
  - It is a sticky flag set by any out-of-range edit or by clamped in_nedits.
  - It clears when the next base word is accepted.
- Not defined:
  - The out_err port is absent.
  - Out-of-range edits and the clamp still behave identically, silently.

## Structure
- Package dna_edit_pkg holds:
  - Digit encoding constants.
  - The ed_op enum (OP_NOP, OP_SUB, OP_INS, OP_DEL).
  - The FSM state enum.
  - Width helper localparams.
- Sub-module dna_edit_apply: a combinational single-edit shift network.
  - Inputs: buffer, len, op, index, digit.
  - Outputs: next buffer, next len, range error.
- The top level contains the FSM, counters and output registers.

## Test plan
All cases use N=6, MAX_ED=4, base word ACGTAC = 12'h1B1.

- Base word, 1 edit INS G at index 2 → out_word=20'h006B1 (ACGGTAC), out_len=7, out_err=0, out_valid at t+2.
- Base word, 1 edit DEL at index 0 → out_word=20'h001B1 (CGTAC), out_len=5.
- Base word, 4 edits back-to-back:
  - Edits: SUB T@5, INS A@0, DEL@6, NOP.
  - Expected → AACGTA, out_word=20'h0006C, out_len=6, out_valid at t+5.
- Out-of-range edit INS@7 on length 6 → word unchanged, 20'h001B1, out_len=6, out_err=1 (with DNA_EDIT_ERR_EN). The next word clears out_err.
- in_nedits=0 with out_ready held low for 3 cycles → out_valid=1 from t+1 with data stable, in_ready=0 until the transfer, then back in IDLE.
- rst asserted after 2 of 3 edits → all outputs 0 and state IDLE. A fresh word with 0 edits returns the unmodified 20'h001B1, out_len=6.
